timer_counter: RTL and testbench

- Counting end of the timer path. It consumes the single-cycle tick enable (clk_ena) produced by the prescaler/clock-select block.
- On each tick it advances an up/down counter, supports synchronous load from a data register, and raises sticky overflow/underflow flags with masked interrupt outputs.
- Sits between the prescaler and the APB register file. The register file drives en/dir/load/tdr/clear/mask and reads cnt/flags.

---
 rtl/timer_pkg.sv | 10 +
 rtl/timer_flag.sv | 27 ++
 rtl/timer_counter.sv | 94 +++++++++
 tb/tb_timer_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer counting path.
package timer_pkg;

   localparam int       TMR_WIDTH = 8;
   localparam logic     DIR_UP    = 1'b0;
   localparam logic     DIR_DOWN  = 1'b1;

   typedef logic [TMR_WIDTH-1:0] tmr_cnt_t;

endpackage

// File: rtl/timer_flag.sv
// Sticky status flag: a set event wins over a simultaneous clear.
module timer_flag (
   input  logic pclk,
   input  logic preset_n,
   input  logic i_set,
   input  logic i_clr,
   output logic o_flag
);

   logic r_flag;

   // Sticky flag register with set-over-clear priority.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_flag <= 1'b0;
      end else if (i_set) begin
         r_flag <= 1'b1;
      end else if (i_clr) begin
         r_flag <= 1'b0;
      end else begin
         r_flag <= r_flag;
      end
   end

   assign o_flag = r_flag;

endmodule

// File: rtl/timer_counter.sv
// Up/down tick counter with synchronous load, sticky wrap flags and masked irq.
module timer_counter
   import timer_pkg::*;
#(
   parameter int               WIDTH   = TMR_WIDTH,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             clk_ena,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] tdr,
   input  logic             clr_ovf,
   input  logic             clr_udf,
   input  logic             ovf_ie,
   input  logic             udf_ie,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf_flag,
   output logic             udf_flag,
   output logic             irq
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_ovf_evt;
   logic             w_udf_evt;
   logic             w_ovf_flag;
   logic             w_udf_flag;

   // Next count and wrap events; a value above MAX_VAL (from a load) wraps at the natural width.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_evt = 1'b0;
      w_udf_evt = 1'b0;
      if (load) begin
         w_cnt_nxt = tdr;
      end else if (en && clk_ena) begin
         if (dir == DIR_DOWN) begin
            if (r_cnt == ZERO) begin
               w_cnt_nxt = MAX_VAL;
               w_udf_evt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
         end else begin
            if ((r_cnt == MAX_VAL) || (r_cnt == ALL_ONES)) begin
               w_cnt_nxt = ZERO;
               w_ovf_evt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Counter register.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_cnt <= ZERO;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   timer_flag u_ovf_flag (
      .pclk     (pclk),
      .preset_n (preset_n),
      .i_set    (w_ovf_evt),
      .i_clr    (clr_ovf),
      .o_flag   (w_ovf_flag)
   );

   timer_flag u_udf_flag (
      .pclk     (pclk),
      .preset_n (preset_n),
      .i_set    (w_udf_evt),
      .i_clr    (clr_udf),
      .o_flag   (w_udf_flag)
   );

   assign cnt      = r_cnt;
   assign ovf_flag = w_ovf_flag;
   assign udf_flag = w_udf_flag;
   assign irq      = (w_ovf_flag & ovf_ie) | (w_udf_flag & udf_ie);

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter against a modular-arithmetic reference model.
module tb_timer_counter;
   import timer_pkg::*;

   logic     pclk;
   logic     preset_n;
   logic     clk_ena;
   logic     en;
   logic     dir;
   logic     load;
   tmr_cnt_t tdr;
   logic     clr_ovf;
   logic     clr_udf;
   logic     ovf_ie;
   logic     udf_ie;
   tmr_cnt_t cnt;
   logic     ovf_flag;
   logic     udf_flag;
   logic     irq;

   int       n_checks;
   int       n_fail;

   // Reference model state
   int       m_cnt;
   logic     m_ovf;
   logic     m_udf;

   timer_counter dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .clk_ena  (clk_ena),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .tdr      (tdr),
      .clr_ovf  (clr_ovf),
      .clr_udf  (clr_udf),
      .ovf_ie   (ovf_ie),
      .udf_ie   (udf_ie),
      .cnt      (cnt),
      .ovf_flag (ovf_flag),
      .udf_flag (udf_flag),
      .irq      (irq)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic exp_irq();
      return (m_ovf & ovf_ie) | (m_udf & udf_ie);
   endfunction

   // One pclk edge: advance the model from the inputs in force at the edge, then settle.
   task automatic step();
      int  nxt;
      logic ev_o;
      logic ev_u;
      @(posedge pclk);
      ev_o = 1'b0;
      ev_u = 1'b0;
      nxt  = m_cnt;
      if (!preset_n) begin
         m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (load) begin
            nxt = int'(tdr);
         end else if (en && clk_ena) begin
            if (dir == DIR_UP) begin
               nxt  = (m_cnt + 1) % 256;
               ev_o = (nxt == 0);
            end else begin
               ev_u = (m_cnt == 0);
               nxt  = (m_cnt + 255) % 256;
            end
         end
         m_cnt = nxt;
         m_ovf = ev_o ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
         m_udf = ev_u ? 1'b1 : (clr_udf ? 1'b0 : m_udf);
      end
      #1;
   endtask

   task automatic test_reset();
      preset_n = 1'b0; clk_ena = 1'b0; en = 1'b0; dir = DIR_UP; load = 1'b0;
      tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0; ovf_ie = 1'b0; udf_ie = 1'b0;
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      step(); step();
      n_checks++;
      if (cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %0h want 00", cnt); end
      n_checks++;
      if ({ovf_flag, udf_flag, irq} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {ovf_flag, udf_flag, irq});
      end
      #3 preset_n = 1'b1;
   endtask

   task automatic test_count_up();
      en = 1'b1; dir = DIR_UP;
      for (int i = 0; i < 20; i++) begin
         clk_ena = ((i % 4) == 3);
         step();
         clk_ena = 1'b0;
         n_checks++;
         if (cnt !== tmr_cnt_t'(m_cnt)) begin
            n_fail++; $display("FAIL count_up_cycle%0d: got %0h want %0h", i, cnt, tmr_cnt_t'(m_cnt));
         end
      end
      n_checks++;
      if (cnt !== 8'h05) begin n_fail++; $display("FAIL count_up_final: got %0h want 05", cnt); end
      n_checks++;
      if ({ovf_flag, udf_flag} !== 2'b00) begin n_fail++; $display("FAIL count_up_flags: got %b want 00", {ovf_flag, udf_flag}); end
   endtask

   task automatic test_ovf_wrap();
      load = 1'b1; tdr = 8'hFE; step(); load = 1'b0;
      n_checks++;
      if (cnt !== 8'hFE) begin n_fail++; $display("FAIL ovf_load: got %0h want fe", cnt); end
      ovf_ie = 1'b1; dir = DIR_UP;
      clk_ena = 1'b1; step();
      n_checks++;
      if (cnt !== 8'hFF || ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %0h/%b want ff/0", cnt, ovf_flag); end
      step(); clk_ena = 1'b0;
      n_checks++;
      if (cnt !== 8'h00 || ovf_flag !== 1'b1 || irq !== 1'b1) begin
         n_fail++; $display("FAIL ovf_wrap: got %0h/%b/%b want 00/1/1", cnt, ovf_flag, irq);
      end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      n_checks++;
      if (ovf_flag !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b/%b want 0/0", ovf_flag, irq); end
   endtask

   task automatic test_udf_wrap();
      udf_ie = 1'b0;
      load = 1'b1; tdr = 8'h01; step(); load = 1'b0;
      dir = DIR_DOWN; clk_ena = 1'b1;
      step();
      n_checks++;
      if (cnt !== 8'h00 || udf_flag !== 1'b0) begin n_fail++; $display("FAIL udf_pre: got %0h/%b want 00/0", cnt, udf_flag); end
      step(); clk_ena = 1'b0;
      n_checks++;
      if (cnt !== 8'hFF || udf_flag !== 1'b1 || irq !== 1'b0) begin
         n_fail++; $display("FAIL udf_wrap: got %0h/%b/%b want ff/1/0", cnt, udf_flag, irq);
      end
      udf_ie = 1'b1; #1;
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL udf_mask_irq: got %b want 1", irq); end
      clr_udf = 1'b1; step(); clr_udf = 1'b0; udf_ie = 1'b0;
      n_checks++;
      if (udf_flag !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b want 0", udf_flag); end
   endtask

   task automatic test_simultaneous();
      dir = DIR_UP; ovf_ie = 1'b0;
      load = 1'b1; tdr = 8'hFF; step(); load = 1'b0;
      clk_ena = 1'b1; clr_ovf = 1'b1; step(); clk_ena = 1'b0; clr_ovf = 1'b0;
      n_checks++;
      if (cnt !== 8'h00 || ovf_flag !== 1'b1) begin
         n_fail++; $display("FAIL set_over_clear: got %0h/%b want 00/1", cnt, ovf_flag);
      end
      load = 1'b1; tdr = 8'h10; clk_ena = 1'b1; step(); load = 1'b0; clk_ena = 1'b0;
      n_checks++;
      if (cnt !== 8'h10) begin n_fail++; $display("FAIL load_over_tick: got %0h want 10", cnt); end
   endtask

   task automatic test_en_freeze();
      tmr_cnt_t base;
      base = cnt;
      en = 1'b0; clk_ena = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if (cnt !== base || ovf_flag !== m_ovf) begin
            n_fail++; $display("FAIL en_freeze_cycle%0d: got %0h/%b want %0h/%b", i, cnt, ovf_flag, base, m_ovf);
         end
      end
      en = 1'b1;
      step(); step(); step();
      clk_ena = 1'b0;
      n_checks++;
      if (cnt !== tmr_cnt_t'(base + 8'd3)) begin n_fail++; $display("FAIL en_resume: got %0h want %0h", cnt, tmr_cnt_t'(base + 8'd3)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         clk_ena = ($urandom_range(0, 2) != 0);
         en      = ($urandom_range(0, 7) != 0);
         dir     = $urandom_range(0, 1) != 0;
         load    = ($urandom_range(0, 15) == 0);
         tdr     = tmr_cnt_t'($urandom_range(0, 255));
         clr_ovf = ($urandom_range(0, 9) == 0);
         clr_udf = ($urandom_range(0, 9) == 0);
         ovf_ie  = $urandom_range(0, 1) != 0;
         udf_ie  = $urandom_range(0, 1) != 0;
         step();
         n_checks++;
         if (cnt !== tmr_cnt_t'(m_cnt) || ovf_flag !== m_ovf || udf_flag !== m_udf || irq !== exp_irq()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got cnt=%0h o=%b u=%b irq=%b want cnt=%0h o=%b u=%b irq=%b",
                     i, cnt, ovf_flag, udf_flag, irq, tmr_cnt_t'(m_cnt), m_ovf, m_udf, exp_irq());
         end
      end
      clk_ena = 1'b0; load = 1'b0; clr_ovf = 1'b0; clr_udf = 1'b0;
   endtask

   task automatic test_async_reset();
      en = 1'b1; dir = DIR_UP;
      load = 1'b1; tdr = 8'hFF; step(); load = 1'b0;
      clk_ena = 1'b1; step(); clk_ena = 1'b0;
      load = 1'b1; tdr = 8'h7A; step(); load = 1'b0;
      n_checks++;
      if (cnt !== 8'h7A || ovf_flag !== 1'b1) begin n_fail++; $display("FAIL async_pre: got %0h/%b want 7a/1", cnt, ovf_flag); end
      #3 preset_n = 1'b0;
      #1;
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      n_checks++;
      if (cnt !== 8'h00 || ovf_flag !== 1'b0 || udf_flag !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: got %0h/%b/%b want 00/0/0", cnt, ovf_flag, udf_flag);
      end
      step();
      #3 preset_n = 1'b1;
      clk_ena = 1'b1; step(); clk_ena = 1'b0;
      n_checks++;
      if (cnt !== 8'h01) begin n_fail++; $display("FAIL async_first_tick: got %0h want 01", cnt); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_count_up();
      test_ovf_wrap();
      test_udf_wrap();
      test_simultaneous();
      test_en_freeze();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
